// File: rtl/csa_resolve_acc.sv
// Resolves redundant (sum, carry) operand pairs into a binary accumulator,
// CHUNK bits per cycle. A group of beats ends with a beat whose last_i is set.
// The result is then held on res_o until the downstream side accepts it.
// Accepting the result clears the accumulator for the next group.
module csa_resolve_acc #(
    parameter int IN_SIZE  = 20,
    parameter int ACC_SIZE = 32,   // must be >= IN_SIZE
    parameter int CHUNK    = 4     // must divide ACC_SIZE
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [IN_SIZE-1:0]  sum_i,
    input  logic [IN_SIZE-1:0]  carry_i,
    input  logic                last_i,
    output logic [ACC_SIZE-1:0] res_o,
    output logic                res_valid_o,
    input  logic                res_ready_i
);

    localparam int NCHUNK = ACC_SIZE / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, ADD, OUT} state_t;

    state_t              state_q, state_d;
    logic                init_q, init_d;
    logic [ACC_SIZE-1:0] acc_q, acc_d;
    logic [ACC_SIZE-1:0] sum_q, sum_d;
    logic [ACC_SIZE-1:0] carry_q, carry_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          cin_q, cin_d;

    logic [31:0]         base;
    logic [CHUNK+1:0]    chunk_res;
    logic                accept;

    // init_q keeps ready_o low while reset is held and until the first edge
    // after release, even though the state register already reads IDLE.
    assign init_d      = 1'b1;
    assign ready_o     = init_q && (state_q == IDLE);
    assign res_valid_o = (state_q == OUT);
    assign res_o       = res_valid_o ? acc_q : '0;
    assign accept      = valid_i && ready_o;
    assign base        = 32'(cnt_q) * 32'(CHUNK);

    // One chunk of acc + sum + carry + cin; the sum never exceeds 3*2^CHUNK-1,
    // so two extra bits hold the carry into the next chunk.
    always_comb begin
        chunk_res = (CHUNK+2)'(acc_q[base +: CHUNK])
                  + (CHUNK+2)'(sum_q[base +: CHUNK])
                  + (CHUNK+2)'(carry_q[base +: CHUNK])
                  + (CHUNK+2)'(cin_q);
    end

    // Next-state and datapath updates for the IDLE / ADD / OUT sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        cin_d   = cin_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sum_d   = ACC_SIZE'($signed(sum_i));
                    carry_d = ACC_SIZE'($signed(carry_i));
                    last_d  = last_i;
                    cnt_d   = '0;
                    cin_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                acc_d[base +: CHUNK] = chunk_res[CHUNK-1:0];
                cin_d = chunk_res[CHUNK+1:CHUNK];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                    // carry out of the top chunk is dropped: modulo 2^ACC_SIZE
                    cnt_d   = '0;
                    cin_d   = '0;
                    state_d = last_q ? OUT : IDLE;
                end
            end
            OUT: begin
                if (res_ready_i) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial accumulation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            cin_q   <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            cin_q   <= cin_d;
        end
    end

endmodule

// File: tb/tb_csa_resolve_acc.sv
// Directed plus randomized bench for csa_resolve_acc with default parameters.
// The reference accumulates sign-extended operands with plain 32-bit adds.
module tb_csa_resolve_acc;

    localparam int IN_SIZE  = 20;
    localparam int ACC_SIZE = 32;
    localparam int CHUNK    = 4;
    localparam int NCHUNK   = ACC_SIZE / CHUNK;

    logic                clk = 1'b0;
    logic                rst_ni = 1'b0;
    logic                valid_i = 1'b0;
    logic                ready_o;
    logic [IN_SIZE-1:0]  sum_i = '0;
    logic [IN_SIZE-1:0]  carry_i = '0;
    logic                last_i = 1'b0;
    logic [ACC_SIZE-1:0] res_o;
    logic                res_valid_o;
    logic                res_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] acc_m = '0;

    csa_resolve_acc #(.IN_SIZE(IN_SIZE), .ACC_SIZE(ACC_SIZE), .CHUNK(CHUNK)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .sum_i(sum_i), .carry_i(carry_i), .last_i(last_i),
        .res_o(res_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sx(input logic [19:0] v);
        return v[19] ? (32'hFFF0_0000 | 32'(v)) : 32'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one beat, then follow it until the block is back in IDLE or OUT.
    task automatic beat(input logic [19:0] s, input logic [19:0] c, input logic l);
        int n;
        bit leak;
        n = 0;
        while (ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(ready_o), 32'd1);
        valid_i = 1'b1; sum_i = s; carry_i = c; last_i = l;
        @(posedge clk); #1;
        acc_m = acc_m + sx(s) + sx(c);
        valid_i = 1'b0;
        sum_i = 20'($urandom); carry_i = 20'($urandom); last_i = 1'($urandom);
        n = 0; leak = 0;
        do begin
            @(negedge clk);
            n++;
            if (res_valid_o !== 1'b1 && res_o !== '0) leak = 1;
        end while (!(ready_o === 1'b1 || res_valid_o === 1'b1) && n < 50);
        chk("latency", 32'(n), 32'(NCHUNK + 1));
        chk("res_zero_busy", 32'(leak), 32'd0);
        chk("next_state", {30'd0, ready_o, res_valid_o}, l ? 32'd1 : 32'd2);
    endtask

    // Check the pending result, optionally stall with ignored valid pulses,
    // then hand it off and confirm the block is idle with a cleared output.
    task automatic take_result(input int hold);
        bit moved;
        bit rdy_seen;
        chk("res_valid", 32'(res_valid_o), 32'd1);
        chk("res_value", res_o, acc_m);
        if (hold > 0) begin
            moved = 0; rdy_seen = 0;
            for (int i = 0; i < hold; i++) begin
                valid_i = 1'($urandom); sum_i = 20'($urandom); carry_i = 20'($urandom);
                last_i = 1'($urandom);
                @(negedge clk);
                if (res_o !== acc_m || res_valid_o !== 1'b1) moved = 1;
                if (ready_o !== 1'b0) rdy_seen = 1;
            end
            valid_i = 1'b0;
            chk("hold_stable", 32'(moved), 32'd0);
            chk("hold_ready_low", 32'(rdy_seen), 32'd0);
        end
        res_ready_i = 1'b1;
        @(posedge clk); #1;
        res_ready_i = 1'b0;
        acc_m = '0;
        @(negedge clk);
        chk("after_handoff", {ready_o, res_valid_o, res_o[29:0]}, 32'h8000_0000);
    endtask

    initial begin
        int nb;
        logic [19:0] rs, rc;

        // reset held: outputs quiet
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_valid", 32'(res_valid_o), 32'd0);
        chk("rst_res", res_o, 32'd0);
        rst_ni = 1'b1;
        #1 chk("rel_ready_before_edge", 32'(ready_o), 32'd0);
        @(negedge clk);
        chk("rel_ready_after_edge", 32'(ready_o), 32'd1);

        // simple add, latency checked inside beat
        beat(20'h00005, 20'h0000A, 1'b1);
        chk("simple_0F", res_o, 32'h0000_000F);
        take_result(0);

        // -1 + 1 wraps to zero
        beat(20'hFFFFF, 20'h00001, 1'b1);
        chk("neg_one_plus_one", res_o, 32'h0);
        take_result(0);

        // carry ripples across several chunks
        beat(20'h7FFFF, 20'h00001, 1'b1);
        chk("carry_chain", res_o, 32'h0008_0000);
        take_result(0);

        // three-beat group
        beat(20'd100, 20'd28, 1'b0);
        beat(20'd100, 20'd28, 1'b0);
        beat(20'd100, 20'd28, 1'b1);
        chk("three_beats", res_o, 32'h0000_0180);
        take_result(0);
        beat(20'd0, 20'd0, 1'b1);
        chk("acc_cleared", res_o, 32'h0);
        take_result(0);

        // back-pressure on the result
        beat(20'h12345, 20'h00F0F, 1'b1);
        take_result(5);

        // reset in the middle of ADD
        @(negedge clk);
        valid_i = 1'b1; sum_i = 20'h0ABCD; carry_i = 20'h01111; last_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_ni = 1'b0;
        #1 chk("abort_outputs", {29'd0, ready_o, res_valid_o, |res_o}, 32'd0);
        acc_m = '0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(ready_o), 32'd1);
        beat(20'd3, 20'd4, 1'b1);
        chk("after_abort", res_o, 32'h0000_0007);
        take_result(0);

        // randomized groups against the arithmetic reference
        for (int g = 0; g < 20; g++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                rs = 20'($urandom);
                rc = 20'($urandom);
                beat(rs, rc, (b == nb - 1));
            end
            take_result($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
